// File: rtl/pio_cmd_pkg.sv
// Shared definitions for the HPS parallel-port command sequencer:
// opcodes, status codes, word field layout and FSM states.
package pio_cmd_pkg;

    // Command word layout (pp_out_axi)
    localparam int CMD_REQ_BIT = 31;
    localparam int CMD_OP_MSB  = 30;
    localparam int CMD_OP_LSB  = 27;
    localparam int CMD_ARG_MSB = 23;
    localparam int CMD_ARG_W   = 24;

    // Response word layout (pp_in_axi)
    localparam int RSP_ACK_BIT  = 31;
    localparam int RSP_BUSY_BIT = 30;
    localparam int RSP_ST_MSB   = 29;
    localparam int RSP_ST_LSB   = 28;
    localparam int RSP_OP_MSB   = 27;
    localparam int RSP_OP_LSB   = 24;
    localparam int RSP_DATA_W   = 24;

    localparam int OP_W     = 4;
    localparam int LED_HPS_W = 9;
    localparam int BLINK_W  = 26;
    localparam int UPTIME_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_NOP         = 4'd0,
        OP_READ_SW     = 4'd1,
        OP_WRITE_LED   = 4'd2,
        OP_SET_BLINK   = 4'd3,
        OP_READ_KEY    = 4'd4,
        OP_READ_UPTIME = 4'd5,
        OP_DELAY       = 4'd6
    } opcode_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_ERR_OP  = 2'd1,
        STAT_ERR_ARG = 2'd2
    } status_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    // Assemble a response word from its fields.
    function automatic logic [31:0] pack_rsp(
        input logic                  ack,
        input logic                  busy,
        input logic [1:0]            status,
        input logic [OP_W-1:0]       op,
        input logic [RSP_DATA_W-1:0] data
    );
        return {ack, busy, status, op, data};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pio_cmd_sequencer.sv
// Command/response sequencer between the HPS parallel-port PIOs and fabric:
// decodes a toggle-handshaked command word, executes it, posts a response.
module pio_cmd_sequencer
    import pio_cmd_pkg::*;
#(
    parameter int SW_W          = 10,
    parameter int KEY_W         = 4,
    parameter int BLINK_DEFAULT = 24999999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      pp_out_axi,
    output logic [31:0]      pp_in_axi,
    input  logic [SW_W-1:0]  sw,
    input  logic [KEY_W-1:0] key,
    output logic [9:0]       led
);

    localparam logic [BLINK_W-1:0] BLINK_RST = BLINK_W'(BLINK_DEFAULT);

    logic [31:0]           cmd_q;
    logic [SW_W-1:0]       sw_sync;
    logic [KEY_W-1:0]      key_sync;
    logic [KEY_W-1:0]      key_pressed;

    state_e                state;
    logic [OP_W-1:0]       op_q;
    logic [CMD_ARG_W-1:0]  arg_q;
    logic [CMD_ARG_W-1:0]  delay_cnt;
    logic                  ack_tog;
    logic                  busy;
    status_e               rsp_status;
    logic [OP_W-1:0]       rsp_op;
    logic [RSP_DATA_W-1:0] rsp_data;
    logic [LED_HPS_W-1:0]  led_reg;

    logic [BLINK_W-1:0]    half_period;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  led_blink;
    logic [UPTIME_W-1:0]   uptime;

    status_e               exec_status;
    logic [RSP_DATA_W-1:0] exec_data;
    logic                  exec_done;
    logic                  set_blink;

    sync_2ff #(.WIDTH(SW_W)) u_sw_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw),
        .q       (sw_sync)
    );

    sync_2ff #(.WIDTH(KEY_W)) u_key_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (key),
        .q       (key_sync)
    );

    // Keys are active-low on the board; report 1 = pressed.
    assign key_pressed = ~key_sync;

    // Same clock domain as the PIO, so a single register stage suffices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cmd_q <= '0;
        else          cmd_q <= pp_out_axi;
    end

    // Per-opcode response data/status, evaluated while in EXEC.
    always_comb begin
        exec_status = STAT_OK;
        exec_data   = '0;
        case (op_q)
            OP_NOP:         exec_data = '0;
            OP_READ_SW:     exec_data = {{(RSP_DATA_W-SW_W){1'b0}}, sw_sync};
            OP_WRITE_LED:   exec_data = {{(RSP_DATA_W-LED_HPS_W){1'b0}}, arg_q[LED_HPS_W-1:0]};
            OP_SET_BLINK: begin
                exec_data = arg_q;
                if (arg_q == '0) exec_status = STAT_ERR_ARG;
            end
            OP_READ_KEY:    exec_data = {{(RSP_DATA_W-KEY_W){1'b0}}, key_pressed};
            OP_READ_UPTIME: exec_data = uptime[UPTIME_W-1:UPTIME_W-RSP_DATA_W];
            OP_DELAY:       exec_data = arg_q;
            default: begin
                exec_status = STAT_ERR_OP;
                exec_data   = '0;
            end
        endcase
    end

    // DELAY holds EXEC until its cycle count matches the operand; all else is one cycle.
    assign exec_done = (op_q != OP_DELAY) || (delay_cnt == arg_q);
    assign set_blink = (state == S_EXEC) && (op_q == OP_SET_BLINK) && (arg_q != '0);

    // Command FSM: detect request toggle, execute, post response and flip ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            arg_q      <= '0;
            delay_cnt  <= '0;
            ack_tog    <= 1'b0;
            busy       <= 1'b0;
            rsp_status <= STAT_OK;
            rsp_op     <= '0;
            rsp_data   <= '0;
            led_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_q[CMD_REQ_BIT] != ack_tog) begin
                        op_q      <= cmd_q[CMD_OP_MSB:CMD_OP_LSB];
                        arg_q     <= cmd_q[CMD_ARG_MSB:0];
                        delay_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        rsp_status <= exec_status;
                        rsp_op     <= op_q;
                        rsp_data   <= exec_data;
                        ack_tog    <= ~ack_tog;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                        if (op_q == OP_WRITE_LED) led_reg <= arg_q[LED_HPS_W-1:0];
                    end else begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // led[0] blinker; a new period restarts the count so it never wraps past 2^26.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_period <= BLINK_RST;
            blink_cnt   <= '0;
            led_blink   <= 1'b0;
        end else if (set_blink) begin
            half_period <= {arg_q, 2'b00} - 1'b1;
            blink_cnt   <= '0;
        end else if (blink_cnt >= half_period) begin
            blink_cnt <= '0;
            led_blink <= ~led_blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Free-running cycle counter; wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) uptime <= '0;
        else          uptime <= uptime + 1'b1;
    end

    assign pp_in_axi = pack_rsp(ack_tog, busy, rsp_status, rsp_op, rsp_data);
    assign led       = {led_reg, led_blink};

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer: expected responses are queued when a
// command is driven and checked when the ack toggle flips.
module tb_pio_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pp_out_axi = '0;
    logic [31:0] pp_in_axi;
    logic [9:0]  sw = '0;
    logic [3:0]  key = 4'hF;
    logic [9:0]  led;

    pio_cmd_sequencer #(
        .SW_W          (10),
        .KEY_W         (4),
        .BLINK_DEFAULT (9)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pp_out_axi (pp_out_axi),
        .pp_in_axi  (pp_in_axi),
        .sw         (sw),
        .key        (key),
        .led        (led)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    logic req = 1'b0;

    // Edges since reset release, mirrors what an uptime counter should hold.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [31:0] rsp(input logic ack, input logic [1:0] st,
                                        input logic [3:0] op, input logic [23:0] data);
        return {ack, 1'b0, st, op, data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [23:0] arg);
        @(negedge clk);
        req = ~req;
        pp_out_axi = {req, op, 3'b000, arg};
    endtask

    task automatic expect_rsp(input logic ack, input logic [1:0] st, input logic [3:0] op,
                              input logic [23:0] data, input int lat, input int busy);
        exp_t e;
        e.word = rsp(ack, st, op, data);
        e.lat  = lat;
        e.busy = busy;
        sb.push_back(e);
    endtask

    // Wait for the ack toggle; optionally drive a new command word mid-wait.
    task automatic wait_resp(input string tag, input int inj_at, input logic [31:0] inj_word);
        exp_t e;
        int   lat;
        int   bz;
        logic prev;
        e    = sb.pop_front();
        prev = pp_in_axi[31];
        lat  = 0;
        bz   = 0;
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (pp_in_axi[30]) bz++;
            if (inj_at != 0 && lat == inj_at) pp_out_axi = inj_word;
            if (pp_in_axi[31] !== prev) break;
        end
        chk({tag, ".word"}, pp_in_axi, e.word);
        chk({tag, ".lat"}, lat, e.lat);
        chk({tag, ".busy"}, bz, e.busy);
    endtask

    // Edges between two consecutive led[0] toggles.
    task automatic measure_blink(input string tag, input int exp);
        logic p;
        int   n;
        p = led[0];
        n = 0;
        while (n < 200 && led[0] === p) begin @(posedge clk); #1; n++; end
        p = led[0];
        n = 0;
        do begin @(posedge clk); #1; n++; end while (n < 200 && led[0] === p);
        chk(tag, n, exp);
    endtask

    initial begin
        logic [31:0] w2;
        logic [23:0] up_exp;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst.pp_in", pp_in_axi, 32'h0);
        chk("rst.led_hps", {22'h0, led[9:1]}, 32'h0);
        measure_blink("blink.default", 10);

        // READ_SW
        sw = 10'h2A5;
        repeat (3) @(negedge clk);
        send(4'd1, 24'd0);
        expect_rsp(1'b1, 2'd0, 4'd1, 24'h2A5, 3, 1);
        wait_resp("read_sw", 0, '0);
        chk("read_sw.raw", pp_in_axi, 32'h810002A5);

        // WRITE_LED with req back to 0
        send(4'd2, 24'h155);
        expect_rsp(1'b0, 2'd0, 4'd2, 24'h155, 3, 1);
        wait_resp("write_led", 0, '0);
        chk("write_led.led", {23'h0, led[9:1]}, 32'h155);

        // Illegal opcode: ERR_OP, LEDs untouched
        send(4'd9, 24'h0000AB);
        expect_rsp(1'b1, 2'd1, 4'd9, 24'h0, 3, 1);
        wait_resp("bad_op", 0, '0);
        chk("bad_op.led", {23'h0, led[9:1]}, 32'h155);

        // SET_BLINK 0: ERR_ARG, period unchanged
        send(4'd3, 24'd0);
        expect_rsp(1'b0, 2'd2, 4'd3, 24'd0, 3, 1);
        wait_resp("blink0", 0, '0);
        measure_blink("blink0.period", 10);

        // SET_BLINK 2: half period 7 -> toggle every 8 edges
        send(4'd3, 24'd2);
        expect_rsp(1'b1, 2'd0, 4'd3, 24'd2, 3, 1);
        wait_resp("blink2", 0, '0);
        measure_blink("blink2.period", 8);
        measure_blink("blink2.period2", 8);

        // READ_KEY: keys 0 and 2 pressed (active-low)
        key = 4'b1010;
        repeat (3) @(negedge clk);
        send(4'd4, 24'd0);
        expect_rsp(1'b0, 2'd0, 4'd4, 24'h5, 3, 1);
        wait_resp("read_key", 0, '0);

        // NOP
        send(4'd0, 24'h123456);
        expect_rsp(1'b1, 2'd0, 4'd0, 24'd0, 3, 1);
        wait_resp("nop", 0, '0);

        // READ_UPTIME: counter is sampled on the response edge (drive + 3)
        repeat (300) @(negedge clk);
        send(4'd5, 24'd0);
        up_exp = 24'((cyc + 2) >> 8);
        expect_rsp(1'b0, 2'd0, 4'd5, up_exp, 3, 1);
        wait_resp("uptime", 0, '0);

        // DELAY 100 with a second toggle (READ_SW) issued mid-delay
        send(4'd6, 24'd100);
        expect_rsp(1'b1, 2'd0, 4'd6, 24'd100, 103, 101);
        w2 = {1'b0, 4'd1, 3'b000, 24'd0};
        wait_resp("delay", 50, w2);
        req = 1'b0;
        expect_rsp(1'b0, 2'd0, 4'd1, 24'h2A5, 2, 1);
        wait_resp("after_delay", 0, '0);

        // Reset during DELAY, req_tog held at 1 -> command re-executes
        send(4'd6, 24'd100);
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst.pp_in", pp_in_axi, 32'h0);
        chk("midrst.led", {22'h0, led}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_rsp(1'b1, 2'd0, 4'd6, 24'd100, 103, 101);
        wait_resp("rerun", 0, '0);
        chk("rerun.led", {22'h0, led[9:1], 1'b0}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
